// File: rtl/mole_scheduler.sv
// Mole sequencer: gap -> draw position (with bounded redraw) -> show -> hit flash or miss, outputs registered.
// Define MOLE_SPEEDUP_EN to shorten show time by level (clamped at MIN_SHOW_TICKS).
module mole_scheduler #(
  parameter int GAP_TICKS      = 25,
  parameter int SHOW_TICKS     = 100,
  parameter int FLASH_TICKS    = 10,
  parameter int MIN_SHOW_TICKS = 40,
  parameter int STEP_TICKS     = 10,
  parameter int MAX_REDRAW     = 3
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       game_en,
  input  logic [2:0] rand_row,
  input  logic [2:0] rand_col,
  input  logic       hit,
  input  logic [3:0] level,
  output logic       mole_valid,
  output logic [2:0] mole_row,
  output logic [2:0] mole_col,
  output logic       mole_hit,
  output logic       mole_miss,
  output logic [3:0] miss_cnt,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {IDLE = 2'b00, GAP = 2'b01, SHOW = 2'b10, FLASH = 2'b11} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       last_vld, last_vld_nx;
  logic [2:0] redraw, redraw_nx;
  logic       valid_nx, hit_nx, miss_nx;
  logic [2:0] row_nx, col_nx;
  logic [3:0] miss_cnt_nx;
  logic [8:0] show_len;
  logic [7:0] show_m1;

`ifdef MOLE_SPEEDUP_EN
  logic [11:0] step_total;
  logic [11:0] show_cut;
  always_comb begin
    step_total = 12'(level) * 12'(STEP_TICKS);
    show_cut   = 12'(SHOW_TICKS) - step_total;
    // Underflow and below-floor both clamp to the minimum show time
    if (step_total >= 12'(SHOW_TICKS) || show_cut < 12'(MIN_SHOW_TICKS))
      show_len = 9'(MIN_SHOW_TICKS);
    else
      show_len = 9'(show_cut);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{level, 8'(MIN_SHOW_TICKS), 8'(STEP_TICKS)};
  assign show_len   = 9'(SHOW_TICKS);
`endif

  assign show_m1 = 8'(show_len - 9'd1);
  assign phase   = state;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_vld   <= 1'b0;
      redraw     <= '0;
      mole_valid <= 1'b0;
      mole_row   <= '0;
      mole_col   <= '0;
      mole_hit   <= 1'b0;
      mole_miss  <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_vld   <= last_vld_nx;
      redraw     <= redraw_nx;
      mole_valid <= valid_nx;
      mole_row   <= row_nx;
      mole_col   <= col_nx;
      mole_hit   <= hit_nx;
      mole_miss  <= miss_nx;
      miss_cnt   <= miss_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_vld_nx = last_vld;
    redraw_nx   = redraw;
    valid_nx    = mole_valid;
    row_nx      = mole_row;
    col_nx      = mole_col;
    hit_nx      = 1'b0;
    miss_nx     = 1'b0;
    miss_cnt_nx = miss_cnt;

    if (!game_en && state != IDLE) begin
      // Interrupted mole: drop silently, keep miss count on display
      state_nx = IDLE;
      valid_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_nx = 1'b0;
          if (game_en) begin
            miss_cnt_nx = '0;
            last_vld_nx = 1'b0;
            cnt_nx      = 8'(GAP_TICKS - 1);
            state_nx    = GAP;
          end
        end
        GAP: begin
          valid_nx = 1'b0;
          if (cnt != 8'd0) begin
            cnt_nx = cnt - 8'd1;
          end else if (last_vld && {rand_row, rand_col} == {mole_row, mole_col}
                       && redraw < 3'(MAX_REDRAW)) begin
            redraw_nx = redraw + 3'd1;
          end else begin
            row_nx      = rand_row;
            col_nx      = rand_col;
            redraw_nx   = '0;
            last_vld_nx = 1'b1;
            cnt_nx      = show_m1;
            valid_nx    = 1'b1;
            state_nx    = SHOW;
          end
        end
        SHOW: begin
          if (hit) begin
            hit_nx   = 1'b1;
            valid_nx = 1'b0;
            cnt_nx   = 8'(FLASH_TICKS - 1);
            state_nx = FLASH;
          end else if (cnt == 8'd0) begin
            miss_nx     = 1'b1;
            valid_nx    = 1'b0;
            miss_cnt_nx = (miss_cnt == 4'd15) ? miss_cnt : miss_cnt + 4'd1;
            cnt_nx      = 8'(GAP_TICKS - 1);
            state_nx    = GAP;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        FLASH: begin
          valid_nx = 1'b0;
          if (cnt != 8'd0) begin
            cnt_nx = cnt - 8'd1;
          end else if (!hit) begin
            // A held key keeps us here so it cannot score the next mole
            cnt_nx   = 8'(GAP_TICKS - 1);
            state_nx = GAP;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed table-driven bench for mole_scheduler with hand-written abort/reset/redraw sequences.
module tb_mole_scheduler;

  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic       game_en = 1'b0;
  logic [2:0] rand_row = '0;
  logic [2:0] rand_col = '0;
  logic       hit = 1'b0;
  logic [3:0] level = '0;
  logic       mole_valid;
  logic [2:0] mole_row;
  logic [2:0] mole_col;
  logic       mole_hit;
  logic       mole_miss;
  logic [3:0] miss_cnt;
  logic [1:0] phase;

  int n_cmp = 0;
  int n_fail = 0;

  always #10 clk_50 = ~clk_50;

  mole_scheduler dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .game_en    (game_en),
    .rand_row   (rand_row),
    .rand_col   (rand_col),
    .hit        (hit),
    .level      (level),
    .mole_valid (mole_valid),
    .mole_row   (mole_row),
    .mole_col   (mole_col),
    .mole_hit   (mole_hit),
    .mole_miss  (mole_miss),
    .miss_cnt   (miss_cnt),
    .phase      (phase)
  );

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [3:0] lvl;
    logic [3:0] lvl2;
    bit         chg;
    int         hit_at;
    int         hit_len;
    int         exp_gap;
    int         exp_vis;
    bit         exp_hit;
    int         exp_flash;
    int         exp_miss;
  } vec_t;

  vec_t vecs[8];

  function automatic int slen(input int lvl);
`ifdef MOLE_SPEEDUP_EN
    int s;
    s = 100 - lvl * 10;
    return (s < 40) ? 40 : s;
`else
    return 100;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Starts with phase just entered GAP; ends with phase just entered GAP again.
  task automatic run_mole(input vec_t v);
    int n;
    int held;
    rand_row = v.row;
    rand_col = v.col;
    level    = v.lvl;
    n = 0;
    while (!mole_valid && n < 1000) begin
      tick();
      n++;
    end
    check("gap_len", n, v.exp_gap);
    check("row", mole_row, v.row);
    check("col", mole_col, v.col);
    check("phase_show", phase, 2);
    n = 1;
    while (n < 1000) begin
      if (v.hit_at != 0 && n == v.hit_at) hit = 1'b1;
      if (v.chg && n == 5) level = v.lvl2;
      tick();
      if (!mole_valid) break;
      n++;
    end
    check("visible_len", n, v.exp_vis);
    check("hit_pulse", mole_hit, v.exp_hit);
    check("miss_pulse", mole_miss, !v.exp_hit);
    if (v.exp_hit) begin
      held = 1;
      n = 0;
      while (phase != 2'b01 && n < 1000) begin
        hit = (held < v.hit_len);
        if (hit) held++;
        tick();
        n++;
        if (n == 1) begin
          check("hit_one_cycle", mole_hit, 0);
          check("flash_valid", mole_valid, 0);
        end
      end
      hit = 1'b0;
      check("flash_len", n, v.exp_flash);
      check("flash_row_held", mole_row, v.row);
    end else begin
      check("phase_gap_after_miss", phase, 1);
    end
    check("miss_cnt", miss_cnt, v.exp_miss);
  endtask

  initial begin
    vec_t w;
    int n;
    vecs[0] = '{3'd3, 3'd4, 4'd0, 4'd0, 1'b0, 0,   0,  25, slen(0), 1'b0, 0,  1};
    vecs[1] = '{3'd3, 3'd4, 4'd0, 4'd0, 1'b0, 0,   0,  28, slen(0), 1'b0, 0,  2};
    vecs[2] = '{3'd1, 3'd5, 4'd0, 4'd0, 1'b0, 10,  30, 25, 10,      1'b1, 30, 2};
    vecs[3] = '{3'd6, 3'd0, 4'd0, 4'd0, 1'b0, 100, 1,  25, 100,     1'b1, 10, 2};
    vecs[4] = '{3'd7, 3'd7, 4'd3, 4'd3, 1'b0, 0,   0,  25, slen(3), 1'b0, 0,  3};
    vecs[5] = '{3'd0, 3'd1, 4'd9, 4'd9, 1'b0, 0,   0,  25, slen(9), 1'b0, 0,  4};
    vecs[6] = '{3'd2, 3'd3, 4'd0, 4'd0, 1'b0, 1,   12, 25, 1,       1'b1, 12, 4};
    vecs[7] = '{3'd4, 3'd4, 4'd3, 4'd9, 1'b1, 0,   0,  25, slen(3), 1'b0, 0,  5};

    #5;
    check("rst_valid", mole_valid, 0);
    check("rst_row", mole_row, 0);
    check("rst_col", mole_col, 0);
    check("rst_hit", mole_hit, 0);
    check("rst_miss", mole_miss, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_phase", phase, 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_phase", phase, 0);

    rand_row = 3'd3;
    rand_col = 3'd4;
    game_en  = 1'b1;
    tick();
    check("start_phase_gap", phase, 1);
    check("start_valid", mole_valid, 0);
    check("start_miss_cnt", miss_cnt, 0);

    for (int i = 0; i < 8; i++) run_mole(vecs[i]);

    // Miss counter saturation
    for (int i = 0; i < 11; i++) begin
      w = '{3'(i % 8), 3'((i + 1) % 8), 4'd0, 4'd0, 1'b0, 0, 0, 25, slen(0), 1'b0, 0,
            (6 + i > 15) ? 15 : 6 + i};
      run_mole(w);
    end

    // Repeat of last position (2,3) twice, then a fresh (2,2) on the third draw
    rand_row = 3'd2;
    rand_col = 3'd3;
    repeat (26) tick();
    check("redraw_still_gap", mole_valid, 0);
    rand_col = 3'd2;
    tick();
    check("redraw_valid", mole_valid, 1);
    check("redraw_row", mole_row, 2);
    check("redraw_col", mole_col, 2);

    // Abort mid-show
    repeat (5) tick();
    game_en = 1'b0;
    tick();
    check("abort_phase", phase, 0);
    check("abort_valid", mole_valid, 0);
    check("abort_miss", mole_miss, 0);
    check("abort_miss_cnt", miss_cnt, 15);
    repeat (3) tick();
    check("abort_idle_hold", phase, 0);
    check("abort_cnt_hold", miss_cnt, 15);

    // Restart clears the miss count; then reset asynchronously during FLASH
    game_en = 1'b1;
    tick();
    check("restart_phase", phase, 1);
    check("restart_miss_cnt", miss_cnt, 0);
    w = '{3'd5, 3'd5, 4'd0, 4'd0, 1'b0, 0, 0, 25, slen(0), 1'b0, 0, 1};
    run_mole(w);
    rand_row = 3'd6;
    rand_col = 3'd6;
    n = 0;
    while (!mole_valid && n < 1000) begin
      tick();
      n++;
    end
    check("pre_rst_gap", n, 25);
    repeat (2) tick();
    hit = 1'b1;
    tick();
    check("pre_rst_hit", mole_hit, 1);
    check("pre_rst_flash", phase, 3);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", mole_valid, 0);
    check("arst_row", mole_row, 0);
    check("arst_col", mole_col, 0);
    check("arst_hit", mole_hit, 0);
    check("arst_miss", mole_miss, 0);
    check("arst_miss_cnt", miss_cnt, 0);
    check("arst_phase", phase, 0);
    hit = 1'b0;
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
